mem_model: RTL

- Simulation-side memory target for the simple mem request interface produced by the HLS AXI-to-mem bridge. It sits directly downstream of that bridge.
- Consumes mem_req/mem_wr traffic and returns read beats on mem_rd from an internal word array.
- Provides a backdoor host port so the testbench can preload and inspect memory without the DPI layer.
- Single clock; all state is local.

---
 rtl/mem_model_pkg.sv | 23 ++
 rtl/mem_model_ram.sv | 28 ++
 rtl/mem_model.sv | 103 ++++++++++
 3 files changed

// File: rtl/mem_model_pkg.sv
// mem_model_pkg: shared state type, opcodes and address-to-word helper for the mem target
package mem_model_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    localparam logic MEM_OP_RD = 1'b0;
    localparam logic MEM_OP_WR = 1'b1;

    function automatic logic [31:0] word_index(
        input logic [63:0] addr,
        input int unsigned data_bits,
        input int unsigned depth_bits
    );
        int unsigned off;
        off = $clog2(data_bits / 8);
        return 32'((addr >> off) & ((64'd1 << depth_bits) - 64'd1));
    endfunction

endpackage

// File: rtl/mem_model_ram.sv
// mem_model_ram: word array with a burst and a host write port and two combinational read ports
module mem_model_ram #(
    parameter int DATA_BITS  = 64,
    parameter int DEPTH_BITS = 10
) (
    input  logic                  clock,
    input  logic                  a_wr_en,
    input  logic [DEPTH_BITS-1:0] a_addr,
    input  logic [DATA_BITS-1:0]  a_wr_data,
    output logic [DATA_BITS-1:0]  a_rd_data,
    input  logic                  b_wr_en,
    input  logic [DEPTH_BITS-1:0] b_addr,
    input  logic [DATA_BITS-1:0]  b_wr_data,
    output logic [DATA_BITS-1:0]  b_rd_data
);

    logic [DATA_BITS-1:0] mem [2**DEPTH_BITS];

    // host write goes first so a same-word burst write overrides it
    always_ff @(posedge clock) begin
        if (b_wr_en) mem[b_addr] <= b_wr_data;
        if (a_wr_en) mem[a_addr] <= a_wr_data;
    end

    assign a_rd_data = mem[a_addr];
    assign b_rd_data = mem[b_addr];

endmodule

// File: rtl/mem_model.sv
// mem_model: simulation memory target serving mem_req/mem_wr bursts and mem_rd beats, with a host backdoor
module mem_model
    import mem_model_pkg::*;
#(
    parameter int MEM_LEN_BITS   = 8,
    parameter int MEM_ADDR_BITS  = 32,
    parameter int MEM_DATA_BITS  = 64,
    parameter int MEM_DEPTH_BITS = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mem_req_valid,
    input  logic                      mem_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]   mem_req_len,
    input  logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    input  logic                      mem_wr_valid,
    input  logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
    output logic                      mem_rd_valid,
    output logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
    input  logic                      mem_rd_ready,
    input  logic                      host_wr_en,
    input  logic [MEM_DEPTH_BITS-1:0] host_addr,
    input  logic [MEM_DATA_BITS-1:0]  host_wr_data,
    output logic [MEM_DATA_BITS-1:0]  host_rd_data,
    output logic                      err_unaligned,
    output logic                      err_abort,
    output logic                      err_stray_wr
);

    localparam int OFF_BITS = $clog2(MEM_DATA_BITS / 8);
    localparam logic [MEM_ADDR_BITS-1:0] OFF_MASK = MEM_ADDR_BITS'((64'd1 << OFF_BITS) - 64'd1);

    state_t                    state, state_next;
    logic [MEM_DEPTH_BITS-1:0] ptr, ptr_next, req_ptr;
    logic [MEM_LEN_BITS-1:0]   cnt, cnt_next;
    logic                      rd_fire, wr_fire, stray, unaligned, last;

    assign req_ptr      = MEM_DEPTH_BITS'(word_index(64'(mem_req_addr), MEM_DATA_BITS, MEM_DEPTH_BITS));
    assign unaligned    = (mem_req_addr & OFF_MASK) != '0;
    assign last         = cnt == '0;
    assign mem_rd_valid = state == READ;
    assign rd_fire      = mem_rd_valid && mem_rd_ready && !mem_req_valid;
    assign wr_fire      = state == WRITE && mem_wr_valid && !mem_req_valid && !reset;
    assign stray        = mem_wr_valid && !wr_fire;

    // a new request always restarts the burst; otherwise each accepted beat advances or finishes it
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        cnt_next   = cnt;
        if (mem_req_valid) begin
            state_next = mem_req_opcode == MEM_OP_WR ? WRITE : READ;
            ptr_next   = req_ptr;
            cnt_next   = mem_req_len;
        end else if (rd_fire || wr_fire) begin
            state_next = last ? IDLE : state;
            ptr_next   = last ? ptr : ptr + MEM_DEPTH_BITS'(1);
            cnt_next   = last ? cnt : cnt - MEM_LEN_BITS'(1);
        end
    end

    // burst state, pointer and remaining-beat count
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            cnt   <= cnt_next;
        end
    end

    // sticky protocol error flags
    always_ff @(posedge clock) begin
        if (reset) begin
            err_unaligned <= 1'b0;
            err_abort     <= 1'b0;
            err_stray_wr  <= 1'b0;
        end else begin
            err_unaligned <= err_unaligned || (mem_req_valid && unaligned);
            err_abort     <= err_abort || (mem_req_valid && state != IDLE);
            err_stray_wr  <= err_stray_wr || stray;
        end
    end

    mem_model_ram #(
        .DATA_BITS (MEM_DATA_BITS),
        .DEPTH_BITS(MEM_DEPTH_BITS)
    ) u_ram (
        .clock    (clock),
        .a_wr_en  (wr_fire),
        .a_addr   (ptr),
        .a_wr_data(mem_wr_bits),
        .a_rd_data(mem_rd_bits),
        .b_wr_en  (host_wr_en),
        .b_addr   (host_addr),
        .b_wr_data(host_wr_data),
        .b_rd_data(host_rd_data)
    );

endmodule
